// File: rtl/paula_fifo_pkg.sv
// paula_fifo_pkg: shared widths for the floppy and audio FIFO uses plus the level-width helper
package paula_fifo_pkg;
  localparam int FLOPPY_DATA_W = 16;
  localparam int FLOPPY_ADDR_W = 11;
  localparam int AUDIO_DATA_W = 16;
  localparam int AUDIO_ADDR_W = 4;
  function automatic int lvl_w(input int addr_w);
    return addr_w + 1;
  endfunction
endpackage

// File: rtl/paula_fifo_ram.sv
// paula_fifo_ram: simple dual-port RAM, synchronous write, look-ahead read feeding the head register
module paula_fifo_ram
  import paula_fifo_pkg::*;
#(
  parameter int DATA_W = FLOPPY_DATA_W,
  parameter int ADDR_W = FLOPPY_ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/paula_dma_fifo.sv
// paula_dma_fifo: parametrised Paula DMA FIFO with level, thresholds, sticky flags, flush; PAULA_FIFO_HWM_EN adds hwm
module paula_dma_fifo
  import paula_fifo_pkg::*;
#(
  parameter int DATA_W = FLOPPY_DATA_W,
  parameter int ADDR_W = FLOPPY_ADDR_W,
  parameter int AFULL_LVL = 2040,
  parameter int AEMPTY_LVL = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clk7_en,
  input  logic              flush,
  input  logic [DATA_W-1:0] in,
  input  logic              wr,
  input  logic              rd,
  output logic [DATA_W-1:0] out,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   level,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow
`ifdef PAULA_FIFO_HWM_EN
  ,
  output logic [ADDR_W:0]   hwm
`endif
);
  localparam int LW = lvl_w(ADDR_W);
  logic [LW-1:0] in_ptr, out_ptr, in_ptr_n, out_ptr_n;
  logic [ADDR_W-1:0] raddr;
  logic [DATA_W-1:0] ram_q, out_n;
  logic clr, we, re, overflow_n, underflow_n;
  assign clr = clk7_en && flush;
  assign empty = in_ptr == out_ptr;
  assign full = (in_ptr[ADDR_W-1:0] == out_ptr[ADDR_W-1:0]) && (in_ptr[ADDR_W] != out_ptr[ADDR_W]);
  assign level = in_ptr - out_ptr;
  assign almost_full = level >= LW'(AFULL_LVL);
  assign almost_empty = level <= LW'(AEMPTY_LVL);
  assign we = clk7_en && !flush && wr && !full;
  assign re = clk7_en && !flush && rd && !empty;
  assign raddr = out_ptr[ADDR_W-1:0] + ADDR_W'(1);
  always_comb begin
    in_ptr_n = clr ? '0 : in_ptr + LW'(we);
    out_ptr_n = clr ? '0 : out_ptr + LW'(re);
    out_n = clr ? '0
          : (we && (empty || (re && level == LW'(1)))) ? in
          : (re && level != LW'(1)) ? ram_q
          : out;
    overflow_n = !clr && (overflow || (clk7_en && wr && full));
    underflow_n = !clr && (underflow || (clk7_en && rd && empty));
  end
  paula_fifo_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk  (clk),
    .we   (we),
    .waddr(in_ptr[ADDR_W-1:0]),
    .wdata(in),
    .raddr(raddr),
    .rdata(ram_q)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      in_ptr <= '0;
      out_ptr <= '0;
      out <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      in_ptr <= in_ptr_n;
      out_ptr <= out_ptr_n;
      out <= out_n;
      overflow <= overflow_n;
      underflow <= underflow_n;
    end
`ifdef PAULA_FIFO_HWM_EN
  logic [LW-1:0] lvl_n;
  assign lvl_n = in_ptr_n - out_ptr_n;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) hwm <= '0;
    else if (clr) hwm <= '0;
    else if (clk7_en && lvl_n > hwm) hwm <= lvl_n;
`endif
endmodule

// File: tb/tb_paula_dma_fifo.sv
// tb_paula_dma_fifo: queue-model scoreboard bench for paula_dma_fifo, directed plus random traffic
module tb_paula_dma_fifo;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 11;
  localparam int DEPTH = 2048;
  localparam int AF = 2040;
  localparam int AE = 8;
  logic clk = 1'b0, reset_n = 1'b0, clk7_en = 1'b0, flush = 1'b0, wr = 1'b0, rd = 1'b0;
  logic [DATA_W-1:0] din = '0, dout;
  logic empty, full, almost_full, almost_empty, overflow, underflow;
  logic [ADDR_W:0] level;
`ifdef PAULA_FIFO_HWM_EN
  logic [ADDR_W:0] hwm;
`endif
  int checks = 0, errors = 0;
  logic [DATA_W-1:0] mq [$];
  logic [DATA_W-1:0] m_out = '0;
  logic m_ovf = 1'b0, m_unf = 1'b0;
  int m_hwm = 0;
  paula_dma_fifo dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .clk7_en     (clk7_en),
    .flush       (flush),
    .in          (din),
    .wr          (wr),
    .rd          (rd),
    .out         (dout),
    .empty       (empty),
    .full        (full),
    .level       (level),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .overflow    (overflow),
    .underflow   (underflow)
`ifdef PAULA_FIFO_HWM_EN
    ,
    .hwm         (hwm)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic model_clear();
    mq.delete();
    m_out = '0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_hwm = 0;
  endtask
  task automatic model_step();
    int n;
    if (!reset_n || (clk7_en && flush)) begin
      model_clear();
      return;
    end
    if (!clk7_en) return;
    n = mq.size();
    if (wr && n == DEPTH) m_ovf = 1'b1;
    if (rd && n == 0) m_unf = 1'b1;
    if (rd && n > 0) void'(mq.pop_front());
    if (wr && n < DEPTH) mq.push_back(din);
    if (mq.size() > 0) m_out = mq[0];
    if (mq.size() > m_hwm) m_hwm = mq.size();
  endtask
  task automatic cyc(input logic e, input logic f, input logic w, input logic r, input logic [DATA_W-1:0] d);
    clk7_en = e;
    flush = f;
    wr = w;
    rd = r;
    din = d;
    @(posedge clk);
    model_step();
    #1;
  endtask
  always @(negedge clk)
    if (reset_n) begin
      chk("level", 32'(level), 32'(mq.size()));
      chk("empty", 32'(empty), 32'(mq.size() == 0));
      chk("full", 32'(full), 32'(mq.size() == DEPTH));
      chk("almost_full", 32'(almost_full), 32'(mq.size() >= AF));
      chk("almost_empty", 32'(almost_empty), 32'(mq.size() <= AE));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("underflow", 32'(underflow), 32'(m_unf));
      chk("out", 32'(dout), 32'(m_out));
`ifdef PAULA_FIFO_HWM_EN
      chk("hwm", 32'(hwm), 32'(m_hwm));
`endif
    end
  initial begin
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_out", 32'(dout), 32'd0);
    chk("rst_aempty", 32'(almost_empty), 32'd1);
    cyc(1, 0, 1, 0, 16'h1111);
    chk("t1_out", 32'(dout), 32'h1111);
    chk("t1_level", 32'(level), 32'd1);
    chk("t1_empty", 32'(empty), 32'd0);
    cyc(1, 1, 0, 0, '0);
    for (int i = 0; i < DEPTH; i++) cyc(1, 0, 1, 0, DATA_W'(i));
    cyc(1, 0, 1, 0, 16'hdead);
    chk("t2_full", 32'(full), 32'd1);
    chk("t2_level", 32'(level), 32'd2048);
    chk("t2_ovf", 32'(overflow), 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      chk("t2_seq", 32'(dout), 32'(i));
      cyc(1, 0, 0, 1, '0);
    end
    chk("t2_empty", 32'(empty), 32'd1);
    cyc(1, 1, 0, 0, '0);
    chk("t2_flush_ovf", 32'(overflow), 32'd0);
    cyc(1, 0, 1, 0, 16'haaaa);
    cyc(1, 0, 1, 1, 16'hbbbb);
    chk("t3_out", 32'(dout), 32'hbbbb);
    chk("t3_level", 32'(level), 32'd1);
    chk("t3_empty", 32'(empty), 32'd0);
    chk("t3_flags", 32'({overflow, underflow}), 32'd0);
    cyc(1, 1, 0, 0, '0);
    for (int i = 1; i <= AF; i++) begin
      cyc(1, 0, 1, 0, DATA_W'(i));
      chk("t4_afull", 32'(almost_full), 32'(i >= AF));
    end
    for (int l = AF - 1; l >= AE; l--) begin
      cyc(1, 0, 0, 1, '0);
      chk("t4_aempty", 32'(almost_empty), 32'(l <= AE));
    end
    cyc(0, 1, 1, 1, 16'h1234);
    chk("t4_hold_level", 32'(level), 32'(AE));
    cyc(1, 1, 0, 0, '0);
`ifdef PAULA_FIFO_HWM_EN
    for (int i = 0; i < 100; i++) cyc(1, 0, 1, 0, DATA_W'(i));
    for (int i = 0; i < 90; i++) cyc(1, 0, 0, 1, '0);
    chk("t6_hwm", 32'(hwm), 32'd100);
    chk("t6_level", 32'(level), 32'd10);
    cyc(1, 1, 0, 0, '0);
    chk("t6_hwm_flush", 32'(hwm), 32'd0);
`endif
    for (int s = 0; s < 5; s++)
      for (int k = 0; k < 1000; k++)
        cyc($urandom_range(3) != 0, $urandom_range(299) == 0,
            $urandom_range(99) < ((s % 2) ? 35 : 75),
            $urandom_range(99) < ((s % 2) ? 75 : 35), DATA_W'($urandom));
    cyc(1, 1, 1, 0, 16'h5555);
    chk("t5_flush_level", 32'(level), 32'd0);
    chk("t5_flush_empty", 32'(empty), 32'd1);
    chk("t5_flush_flags", 32'({overflow, underflow}), 32'd0);
    cyc(1, 0, 0, 0, '0);
    chk("t5_write_dropped", 32'(empty), 32'd1);
    cyc(1, 0, 0, 1, '0);
    chk("t6_unf", 32'(underflow), 32'd1);
    for (int i = 0; i < 5; i++) cyc(1, 0, 1, 0, DATA_W'(16'h0100 + i));
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_level", 32'(level), 32'd0);
    chk("ar_empty", 32'(empty), 32'd1);
    chk("ar_full", 32'(full), 32'd0);
    chk("ar_out", 32'(dout), 32'd0);
    chk("ar_thresh", 32'({almost_full, almost_empty}), 32'd1);
    chk("ar_flags", 32'({overflow, underflow}), 32'd0);
`ifdef PAULA_FIFO_HWM_EN
    chk("ar_hwm", 32'(hwm), 32'd0);
`endif
    model_clear();
    @(posedge clk);
    #1 reset_n = 1'b1;
    cyc(1, 0, 1, 0, 16'h7777);
    chk("ar_post_out", 32'(dout), 32'h7777);
    chk("ar_post_level", 32'(level), 32'd1);
    cyc(0, 0, 0, 0, '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
